// File: rtl/morse_pkg.sv
// Shared Morse constants for the encoder FSM and the symbol decoder:
// symbol codes, letter codes, reference element patterns and decoder states.
package morse_pkg;

   // 2-bit Morse bus symbols
   localparam logic [1:0] MORSE_GAP  = 2'b00;
   localparam logic [1:0] MORSE_DOT  = 2'b01;
   localparam logic [1:0] MORSE_DASH = 2'b10;
   localparam logic [1:0] MORSE_EOL  = 2'b11;

   // 3-bit switch letter codes
   localparam logic [2:0] LTR_H     = 3'b000;
   localparam logic [2:0] LTR_E     = 3'b001;
   localparam logic [2:0] LTR_L     = 3'b010;
   localparam logic [2:0] LTR_O     = 3'b011;
   localparam logic [2:0] LTR_BLANK = 3'b100;
   localparam logic [2:0] LTR_ERR   = 3'b111;

   // Element count: 3 bits, saturating at ELEM_OVF to flag an overlong letter
   localparam int         ELEM_CNT_W = 3;
   localparam logic [2:0] ELEM_OVF   = 3'd5;

   // Reference patterns (Dot=0, Dash=1, first element in the highest used bit)
   localparam logic [3:0] PAT_H = 4'b0000;
   localparam logic [2:0] CNT_H = 3'd4;
   localparam logic [3:0] PAT_E = 4'b0000;
   localparam logic [2:0] CNT_E = 3'd1;
   localparam logic [3:0] PAT_L = 4'b0100;
   localparam logic [2:0] CNT_L = 3'd4;
   localparam logic [3:0] PAT_O = 4'b0111;
   localparam logic [2:0] CNT_O = 3'd3;

   // Decoder FSM states; encodings are what the debug port shows
   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_MARK       = 4'd1,
      ST_SPACE      = 4'd2,
      ST_EMIT       = 4'd3,
      ST_WAIT_BLANK = 4'd4
   } dec_state_t;

   // Saturating element-count increment
   function automatic logic [2:0] elem_cnt_inc(input logic [2:0] cnt);
      return (cnt >= ELEM_OVF) ? ELEM_OVF : cnt + 3'd1;
   endfunction

endpackage

// File: rtl/morse_pattern_match.sv
// Combinational lookup of a captured (element count, pattern) pair to a
// letter code; anything that is not H/E/L/O reports the error code.
module morse_pattern_match
   import morse_pkg::*;
(
   input  logic [2:0] i_count,
   input  logic [3:0] i_pattern,
   output logic [2:0] o_letter,
   output logic       o_error
);

   // Table index equals the letter code (H=0, E=1, L=2, O=3)
   localparam logic [3:0][3:0] REF_PAT = {PAT_O, PAT_L, PAT_E, PAT_H};
   localparam logic [3:0][2:0] REF_CNT = {CNT_O, CNT_L, CNT_E, CNT_H};

   logic [3:0] w_hit;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ref
         assign w_hit[gi] = (i_count == REF_CNT[gi]) && (i_pattern == REF_PAT[gi]);
      end
   endgenerate

   // Reference entries are mutually exclusive, so at most one hit wins
   always_comb begin
      o_letter = LTR_ERR;
      o_error  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (w_hit[i]) begin
            o_letter = 3'(i);
            o_error  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder: rebuilds H/E/L/O/Blank letter codes from the 2-bit
// Morse bus, one Valid pulse per letter. All outputs are registered.
// Optional macro MORSE_DEC_STATE_DBG_EN adds the DecState debug output.
module morse_symbol_decoder
   import morse_pkg::*;
#(
   parameter int GAP_CYCLES   = 3,
   parameter int BLANK_CYCLES = 7,
   parameter int CNT_W        = 4
)(
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [1:0] Morse,
   output logic [2:0] Letter,
   output logic       Valid,
`ifdef MORSE_DEC_STATE_DBG_EN
   output logic       Error,
   output logic [3:0] DecState
`else
   output logic       Error
`endif
);

   dec_state_t      r_state, w_state_next;
   logic [3:0]      r_pattern, w_pattern_next;
   logic [2:0]      r_count, w_count_next;
   logic [CNT_W-1:0] r_gap, w_gap_next;
   logic [1:0]      r_mark, w_mark_next;
   logic [2:0]      r_letter, w_letter_next;
   logic            r_valid, w_valid_next;
   logic            r_error, w_error_next;

   logic            w_is_mark;
   logic            w_elem;
   logic [CNT_W-1:0] w_gap_inc;
   logic [2:0]      w_match_letter;
   logic            w_match_error;

   assign w_is_mark = (Morse == MORSE_DOT) || (Morse == MORSE_DASH);
   assign w_elem    = (Morse == MORSE_DASH);
   assign w_gap_inc = r_gap + CNT_W'(1);

   morse_pattern_match u_match (
      .i_count   (r_count),
      .i_pattern (r_pattern),
      .o_letter  (w_match_letter),
      .o_error   (w_match_error)
   );

   // State and datapath registers; reset discards any partial letter
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state   <= ST_IDLE;
         r_pattern <= '0;
         r_count   <= '0;
         r_gap     <= '0;
         r_mark    <= MORSE_GAP;
         r_letter  <= LTR_BLANK;
         r_valid   <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pattern <= w_pattern_next;
         r_count   <= w_count_next;
         r_gap     <= w_gap_next;
         r_mark    <= w_mark_next;
         r_letter  <= w_letter_next;
         r_valid   <= w_valid_next;
         r_error   <= w_error_next;
      end
   end

   // Next-state, element capture and output-pulse decisions
   always_comb begin
      w_state_next   = r_state;
      w_pattern_next = r_pattern;
      w_count_next   = r_count;
      w_gap_next     = r_gap;
      w_mark_next    = r_mark;
      w_letter_next  = r_letter;
      w_valid_next   = 1'b0;
      w_error_next   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_is_mark) begin
               w_state_next   = ST_MARK;
               w_pattern_next = {3'b000, w_elem};
               w_count_next   = 3'd1;
               w_mark_next    = Morse;
               w_gap_next     = '0;
            end
         end

         ST_MARK: begin
            if (w_is_mark) begin
               // A direct Dot<->Dash change is a new element; a repeat is not
               if (Morse != r_mark) begin
                  w_pattern_next = {r_pattern[2:0], w_elem};
                  w_count_next   = elem_cnt_inc(r_count);
                  w_mark_next    = Morse;
               end
            end else if (Morse == MORSE_GAP) begin
               w_state_next = ST_SPACE;
               w_gap_next   = CNT_W'(1);
            end else begin
               w_state_next  = ST_EMIT;
               w_gap_next    = '0;
               w_valid_next  = 1'b1;
               w_letter_next = w_match_letter;
               w_error_next  = w_match_error;
            end
         end

         ST_SPACE: begin
            if (Morse == MORSE_GAP) begin
               w_gap_next = w_gap_inc;
               if (int'(w_gap_inc) >= GAP_CYCLES) begin
                  w_state_next  = ST_EMIT;
                  w_valid_next  = 1'b1;
                  w_letter_next = w_match_letter;
                  w_error_next  = w_match_error;
               end
            end else if (w_is_mark) begin
               w_state_next   = ST_MARK;
               w_pattern_next = {r_pattern[2:0], w_elem};
               w_count_next   = elem_cnt_inc(r_count);
               w_mark_next    = Morse;
               w_gap_next     = '0;
            end else begin
               w_state_next  = ST_EMIT;
               w_gap_next    = '0;
               w_valid_next  = 1'b1;
               w_letter_next = w_match_letter;
               w_error_next  = w_match_error;
            end
         end

         ST_EMIT: begin
            // Letter already registered on entry; start the next one clean
            w_pattern_next = '0;
            w_count_next   = '0;
            if (Morse == MORSE_GAP) begin
               w_state_next = ST_WAIT_BLANK;
               w_gap_next   = w_gap_inc;
            end else if (w_is_mark) begin
               w_state_next   = ST_MARK;
               w_pattern_next = {3'b000, w_elem};
               w_count_next   = 3'd1;
               w_mark_next    = Morse;
               w_gap_next     = '0;
            end else begin
               w_state_next = ST_WAIT_BLANK;
               w_gap_next   = '0;
            end
         end

         ST_WAIT_BLANK: begin
            if (Morse == MORSE_GAP) begin
               w_gap_next = w_gap_inc;
               if (int'(w_gap_inc) >= BLANK_CYCLES) begin
                  w_state_next  = ST_IDLE;
                  w_gap_next    = '0;
                  w_valid_next  = 1'b1;
                  w_letter_next = LTR_BLANK;
               end
            end else if (w_is_mark) begin
               w_state_next   = ST_MARK;
               w_pattern_next = {3'b000, w_elem};
               w_count_next   = 3'd1;
               w_mark_next    = Morse;
               w_gap_next     = '0;
            end else begin
               w_state_next = ST_IDLE;
               w_gap_next   = '0;
            end
         end

         default: begin
            w_state_next   = ST_IDLE;
            w_pattern_next = '0;
            w_count_next   = '0;
            w_gap_next     = '0;
         end
      endcase
   end

   assign Letter = r_letter;
   assign Valid  = r_valid;
   assign Error  = r_error;

`ifdef MORSE_DEC_STATE_DBG_EN
   assign DecState = r_state;
`endif

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Self-checking bench for morse_symbol_decoder: expected letters are queued
// when the terminating symbol is driven and checked when Valid pulses.
module tb_morse_symbol_decoder;
   import morse_pkg::*;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b0;
   logic [1:0] Morse = MORSE_GAP;
   logic [2:0] Letter;
   logic       Valid;
   logic       Error;
`ifdef MORSE_DEC_STATE_DBG_EN
   logic [3:0] DecState;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit armed   = 1'b0;

   typedef struct {
      logic [2:0] letter;
      logic       error;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   morse_symbol_decoder dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .Morse    (Morse),
      .Letter   (Letter),
      .Valid    (Valid),
`ifdef MORSE_DEC_STATE_DBG_EN
      .Error    (Error),
      .DecState (DecState)
`else
      .Error    (Error)
`endif
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Drive one symbol for one cycle; optionally queue the letter it completes
   task automatic send(input logic [1:0] sym, input bit exp_v, input logic [2:0] exp_l);
      exp_t e;
      Morse = sym;
      if (exp_v) begin
         e.letter = exp_l;
         e.error  = (exp_l == LTR_ERR);
         e.cyc    = cyc + 1;
         exp_q.push_back(e);
         $display("[TB] cycle %0d: expect letter %0d error %0d", e.cyc, e.letter, e.error);
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic gaps(input int n);
      for (int i = 0; i < n; i++) send(MORSE_GAP, 1'b0, LTR_H);
   endtask

   // Monitor: every Valid pulse must match the head of the scoreboard
   always @(negedge Clock) begin
      if (armed) begin
         if (Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               $display("[TB] cycle %0d: valid letter %0d error %0d", cyc, Letter, Error);
               chk("letter", int'(Letter), int'(e.letter));
               chk("error", int'(Error), int'(e.error));
               chk("valid_cycle", cyc, e.cyc);
            end
         end
         chk("error_without_valid", int'(Error === 1'b1 && Valid !== 1'b1), 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      Resetn = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("reset_letter", int'(Letter), int'(LTR_BLANK));
      chk("reset_valid", int'(Valid), 0);
      chk("reset_error", int'(Error), 0);
      armed  = 1'b1;
      Resetn = 1'b1;

      // H with single-cycle dots
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H);
      gaps(2); send(MORSE_GAP, 1, LTR_H);

      // O with two-cycle dashes, each run counted once
      for (int k = 0; k < 3; k++) begin
         send(MORSE_DASH, 0, LTR_H); send(MORSE_DASH, 0, LTR_H);
         if (k < 2) send(MORSE_GAP, 0, LTR_H);
      end
      gaps(2); send(MORSE_GAP, 1, LTR_O);

      // L then idle: blank after the 7th gap, then nothing more
      send(MORSE_DOT, 0, LTR_H);  send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DASH, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H);  send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H);
      gaps(2); send(MORSE_GAP, 1, LTR_L);
      gaps(3); send(MORSE_GAP, 1, LTR_BLANK);
      gaps(5);

      // Overflow: five dots
      for (int k = 0; k < 5; k++) begin
         send(MORSE_DOT, 0, LTR_H);
         if (k < 4) send(MORSE_GAP, 0, LTR_H);
      end
      gaps(2); send(MORSE_GAP, 1, LTR_ERR);
      gaps(3); send(MORSE_GAP, 1, LTR_BLANK);

      // Explicit end-of-letter, then back-to-back H with no blank
      send(MORSE_DOT, 0, LTR_H); send(MORSE_EOL, 1, LTR_E);
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H);
      gaps(2); send(MORSE_GAP, 1, LTR_H);

      // Direct Dot->Dash->Dot changes with no gap form separate elements (L)
      send(MORSE_DOT, 0, LTR_H); send(MORSE_DASH, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H);
      gaps(2); send(MORSE_GAP, 1, LTR_L);

      // Reset mid-letter discards the partial pattern
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      send(MORSE_DOT, 0, LTR_H); send(MORSE_GAP, 0, LTR_H);
      Morse  = MORSE_GAP;
      Resetn = 1'b0;
      @(posedge Clock);
      #1;
      chk("midreset_letter", int'(Letter), int'(LTR_BLANK));
      chk("midreset_valid", int'(Valid), 0);
      Resetn = 1'b1;
      send(MORSE_DOT, 0, LTR_H);
      gaps(2); send(MORSE_GAP, 1, LTR_E);
      gaps(3); send(MORSE_GAP, 1, LTR_BLANK);
      gaps(6);

      chk("pending_expectations", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
